// File: rtl/debounce_bank.sv
// Multi-channel synchronising switch debouncer with rise/fall event pulses.
// Optional sticky event flags and interrupt are built when DEBOUNCE_IRQ_EN is defined.
module debounce_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                busy,
    input  logic [CHANNELS-1:0] evt_clr,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        PEND_HI = 2'd1,
        IDLE_HI = 2'd2,
        PEND_LO = 2'd3
    } state_t;

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0]    r_cnt  [CHANNELS];
    logic [CHANNELS-1:0] r_dout;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic                r_busy;

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_s_nxt;
    logic [CNT_W:0]      w_thr_eff;
    state_t              w_state    [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_nxt  [CHANNELS];
    logic [CHANNELS-1:0] w_dout_nxt;
    logic [CHANNELS-1:0] w_rise_nxt;
    logic [CHANNELS-1:0] w_fall_nxt;
    logic                w_busy_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_s_nxt   = r_sync[SYNC_STAGES-2];
    assign w_thr_eff = (threshold == '0) ? (CNT_W+1)'(1) : {1'b0, threshold};

    // State register: synchroniser chain, counters, stable level and event pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
            r_dout <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_busy <= 1'b0;
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_dout <= w_dout_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Next-state: count qualifying mismatching samples, flip once the threshold is reached.
    always_comb begin
        w_dout_nxt = r_dout;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_state[i]   = state_t'({r_dout[i], (r_cnt[i] != '0) || (w_s[i] != r_dout[i])});
            case (w_state[i])
                IDLE_LO, IDLE_HI: w_cnt_nxt[i] = '0;
                PEND_HI, PEND_LO: begin
                    // A leftover count with the input back at the stable level is a glitch.
                    if (w_s[i] == r_dout[i]) begin
                        w_cnt_nxt[i] = '0;
                    end else if (en) begin
                        if (({1'b0, r_cnt[i]} + (CNT_W+1)'(1)) >= w_thr_eff) begin
                            w_dout_nxt[i] = ~r_dout[i];
                            w_cnt_nxt[i]  = '0;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                        end
                    end
                end
                default: w_cnt_nxt[i] = '0;
            endcase
        end
    end

    // Output decode: busy looks one sample ahead so the register matches the current state.
    always_comb begin
        w_rise_nxt = w_dout_nxt & ~r_dout;
        w_fall_nxt = ~w_dout_nxt & r_dout;
        w_busy_nxt = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((w_cnt_nxt[i] != '0) || (w_s_nxt[i] != w_dout_nxt[i])) w_busy_nxt = 1'b1;
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

`ifdef DEBOUNCE_IRQ_EN
    logic [CHANNELS-1:0] r_pending;
    logic                r_irq;
    logic [CHANNELS-1:0] w_pending_nxt;

    // Sticky flags: a new event wins over a simultaneous clear.
    assign w_pending_nxt = (r_pending & ~evt_clr) | r_rise | r_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_irq     <= |w_pending_nxt;
        end
    end

    assign pending = r_pending;
    assign irq     = r_irq;
`else
    logic w_unused_evt_clr;
    assign w_unused_evt_clr = ^evt_clr;
    assign pending          = '0;
    assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised bench for debounce_bank against a streak-counting model, with directed literal checks.
module tb_debounce_bank;
    localparam int unsigned CH = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] threshold;
    logic [CH-1:0] din;
    logic [CH-1:0] dout, rise, fall, pending, evt_clr;
    logic          busy, irq;

    debounce_bank #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .threshold(threshold), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .busy(busy),
        .evt_clr(evt_clr), .pending(pending), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: s is din seen SS edges ago; streak counts consecutive enabled samples with s != dout.
    bit [CH-1:0] m_hist [SS];
    int          m_streak [CH];
    bit [CH-1:0] m_dout, m_rise, m_fall, m_pend;
    bit          m_busy, m_irq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int thr;
        bit [CH-1:0] new_pend;
        if (!rst) begin
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            for (int c = 0; c < CH; c++) m_streak[c] = 0;
            m_dout = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_busy = 0; m_irq = 0;
        end else begin
            thr = (threshold == 0) ? 1 : int'(threshold);
            new_pend = (m_pend & ~evt_clr) | m_rise | m_fall;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < CH; c++) begin
                if (m_hist[SS-1][c] != m_dout[c]) begin
                    if (en) begin
                        m_streak[c]++;
                        if (m_streak[c] >= thr) begin
                            m_dout[c] = ~m_dout[c];
                            m_streak[c] = 0;
                            if (m_dout[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                        end
                    end
                end else begin
                    m_streak[c] = 0;
                end
            end
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = din;
`ifdef DEBOUNCE_IRQ_EN
            m_pend = new_pend;
`else
            m_pend = '0;
`endif
            m_irq = |m_pend;
            m_busy = 0;
            for (int c = 0; c < CH; c++)
                if (m_hist[SS-1][c] != m_dout[c] || m_streak[c] != 0) m_busy = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("rise", 32'(rise), 32'(m_rise));
            chk("fall", 32'(fall), 32'(m_fall));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; threshold = 4'd5; din = '0; evt_clr = '0;
        step(2);
        chk_en = 1'b1;
        step(1);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1;

        // Clean rise on ch0: 2 sync edges + 5 samples.
        step(1);
        din = 4'b0001;
        step(2);
        chk("rise0_busy", 32'(busy), 32'h1);
        step(4);
        chk("rise0_early", 32'(dout), 32'h0);
        step(1);
        chk("rise0_dout", 32'(dout), 32'h1);
        chk("rise0_pulse", 32'(rise), 32'h1);
        step(1);
        chk("rise0_pulse_end", 32'(rise), 32'h0);

        // Bounce on ch1: 4 high, 1 low, then held.
        din = 4'b0011;
        step(4);
        din = 4'b0001;
        step(1);
        din = 4'b0011;
        step(6);
        chk("bounce_early", 32'(dout), 32'h1);
        step(1);
        chk("bounce_dout", 32'(dout), 32'h3);
        chk("bounce_rise", 32'(rise), 32'h2);

        // Simultaneous rise on ch2 and fall on ch3.
        din = 4'b1000;
        step(12);
        chk("pre_sim_dout", 32'(dout), 32'h8);
        din = 4'b0100;
        step(6);
        chk("sim_early", 32'(rise | fall), 32'h0);
        step(1);
        chk("sim_rise", 32'(rise), 32'h4);
        chk("sim_fall", 32'(fall), 32'h8);
        step(1);
`ifdef DEBOUNCE_IRQ_EN
        chk("sim_pend", 32'(pending[3:2]), 32'h3);
        chk("sim_irq", 32'(irq), 32'h1);
`else
        chk("sim_pend", 32'(pending), 32'h0);
        chk("sim_irq", 32'(irq), 32'h0);
`endif
        // Clear all flags, then a clear coinciding with a new fall on ch2 must lose.
        evt_clr = 4'hF;
        din = 4'b0000;
        step(1);
        evt_clr = '0;
        chk("clr_pend", 32'(pending), 32'h0);
        step(6);
        chk("fall2_pulse", 32'(fall), 32'h4);
        evt_clr = 4'b0100;
        step(1);
        evt_clr = '0;
`ifdef DEBOUNCE_IRQ_EN
        chk("setwins_pend", 32'(pending), 32'h4);
`else
        chk("setwins_pend", 32'(pending), 32'h0);
`endif

        // Enable gating: en every 4th cycle, threshold 3 on ch2.
        threshold = 4'd3;
        din = 4'b0100;
        for (int t = 0; t < 40; t++) begin
            en = (t % 4 == 3);
            step(1);
        end
        chk("gated_dout", 32'(dout), 32'h4);
        en = 1'b1;

        // Reset mid-count on ch0.
        din = 4'b0101;
        threshold = 4'd5;
        step(5);
        rst = 1'b0;
        step(1);
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_rise", 32'(rise), 32'h0);
        rst = 1'b1;
        step(6);
        chk("postrst_early", 32'(dout), 32'h0);
        step(1);
        chk("postrst_dout", 32'(dout), 32'h5);

        // Randomised phase.
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < int'(CH); c++)
                if ($urandom_range(0, 7) == 0) din[c] = ~din[c];
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) threshold = CW'($urandom_range(0, 15));
            evt_clr = ($urandom_range(0, 3) == 0) ? CH'($urandom_range(0, 15)) : '0;
            rst = ($urandom_range(0, 199) != 0);
            step(1);
        end
        rst = 1'b1;
        step(1);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
